// File: rtl/tinynpu_pkg.sv
// tinynpu_pkg: shared row geometry, row type and row packer state encoding
package tinynpu_pkg;
  localparam int ROW_BYTES = 176;
  localparam int SDRAM_WORD_BYTES = 16;
  typedef logic [ROW_BYTES*8-1:0] row_t;
  typedef enum logic [1:0] {RP_IDLE, RP_RUN, RP_DONE} row_packer_state_e;
endpackage

// File: rtl/sdram_row_packer_row_out_reg.sv
// row_out_reg: single-entry valid/ready register that can reload in the cycle it drains
module row_out_reg #(
  parameter int W = 1408
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] data
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  always_comb begin
    valid_d = load || (valid_q && !ready);
    data_d = load ? load_data : data_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
  assign valid = valid_q;
  assign data = data_q;
endmodule

// File: rtl/sdram_row_packer.sv
// sdram_row_packer: fetches SDRAM words and packs 11 per row with credit-bounded read-ahead; ROW_PACKER_STALL_CNT_EN enables stall_cycles
module sdram_row_packer
  import tinynpu_pkg::*;
#(
  parameter int SDRAM_DATA_W = 128,
  parameter int WORDS_PER_ROW = 11,
  parameter int LINE_NUM_W = 11,
  parameter int ADDR_INC = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [31:0]                           base_addr,
  input  logic [LINE_NUM_W-1:0]                 row_count,
  output logic                                  busy,
  output logic                                  done,
  output logic [31:0]                           rd_addr,
  output logic                                  rd_read,
  input  logic                                  rd_waitrequest,
  input  logic [SDRAM_DATA_W-1:0]               rd_data,
  input  logic                                  rd_datavalid,
  output logic [SDRAM_DATA_W*WORDS_PER_ROW-1:0] row_data,
  output logic                                  row_valid,
  input  logic                                  row_ready,
  output logic [31:0]                           stall_cycles
);
  localparam int ROW_W = SDRAM_DATA_W * WORDS_PER_ROW;
  localparam int KW = $clog2(WORDS_PER_ROW);
  localparam logic [15:0] WPR = 16'(WORDS_PER_ROW);
  localparam logic [15:0] CREDIT = 16'(2 * WORDS_PER_ROW);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS_PER_ROW - 1);
  row_packer_state_e     state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [15:0]           issued_q, issued_d, total_q, total_d, in_flight;
  logic [LINE_NUM_W-1:0] rows_q, rows_d, acc_q, acc_d;
  logic [KW-1:0]         k_q, k_d;
  logic [ROW_W-1:0]      asm_q, asm_d, asm_w;
  logic                  full_q, full_d;
  logic                  run, accept, take, word, last_word, load;
  always_comb begin
    run = state_q == RP_RUN;
    in_flight = issued_q - 16'(acc_q) * WPR;
    rd_read = run && issued_q < total_q && in_flight < CREDIT;
    accept = rd_read && !rd_waitrequest;
    take = row_valid && row_ready;
    word = run && rd_datavalid;
    last_word = word && k_q == K_LAST;
    asm_w = asm_q;
    if (word) asm_w[SDRAM_DATA_W*int'(k_q) +: SDRAM_DATA_W] = rd_data;
    // a completed row waits in the assembly buffer until the output register frees up
    load = run && (full_q || last_word) && (!row_valid || row_ready);
    full_d = run && (full_q || last_word) && !load;
    k_d = (!run || last_word) ? '0 : word ? k_q + KW'(1) : k_q;
    asm_d = asm_w;
    addr_d = accept ? addr_q + ADDR_INC : addr_q;
    issued_d = accept ? issued_q + 16'd1 : issued_q;
    acc_d = take ? acc_q + LINE_NUM_W'(1) : acc_q;
    total_d = total_q;
    rows_d = rows_q;
    state_d = state_q;
    case (state_q)
      RP_IDLE: if (start) begin
        state_d = row_count != '0 ? RP_RUN : RP_DONE;
        addr_d = base_addr;
        issued_d = '0;
        acc_d = '0;
        k_d = '0;
        full_d = 1'b0;
        total_d = 16'(row_count) * WPR;
        rows_d = row_count;
      end
      RP_RUN: state_d = (take && acc_d == rows_q) ? RP_DONE : RP_RUN;
      default: state_d = RP_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RP_IDLE;
      addr_q <= '0;
      issued_q <= '0;
      total_q <= '0;
      rows_q <= '0;
      acc_q <= '0;
      k_q <= '0;
      asm_q <= '0;
      full_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      issued_q <= issued_d;
      total_q <= total_d;
      rows_q <= rows_d;
      acc_q <= acc_d;
      k_q <= k_d;
      asm_q <= asm_d;
      full_q <= full_d;
    end
  end
  row_out_reg #(.W(ROW_W)) u_out (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .load_data(asm_w),
    .valid(row_valid),
    .ready(row_ready),
    .data(row_data)
  );
  assign rd_addr = addr_q;
  assign busy = run;
  assign done = state_q == RP_DONE;
`ifdef ROW_PACKER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  always_comb
    stall_d = (state_q == RP_IDLE && start) ? '0 :
              (run && row_valid && !row_ready && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge clk) begin
    if (!rst_n) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_sdram_row_packer.sv
// tb_sdram_row_packer: SDRAM responder, row scoreboard and directed scenarios for sdram_row_packer
module tb_sdram_row_packer;
  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0]   base_addr = '0;
  logic [10:0]   row_count = '0;
  logic          busy, done, rd_read, row_valid;
  logic          rd_waitrequest = 1'b0, rd_datavalid = 1'b0, row_ready = 1'b0;
  logic [31:0]   rd_addr, stall_cycles;
  logic [127:0]  rd_data = '0;
  logic [1407:0] row_data;
  int errs = 0, checks = 0, cyc = 0;
  int ready_mode = 0, wait_pct = 0, dv_gap = 0;
  int n_issued = 0, n_rows = 0, hs_cyc = 0, start_cyc = 0;
  bit rd_seen = 0, prev_stall = 0;
  logic [31:0] cur_base = '0, tag = '0, last_addr = '0, prev_addr = '0;
  logic [127:0] pend[$];
  logic [1407:0] exp_rows[$];
  logic [1407:0] last_row = '0;

  sdram_row_packer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .row_count(row_count),
    .busy(busy), .done(done), .rd_addr(rd_addr), .rd_read(rd_read),
    .rd_waitrequest(rd_waitrequest), .rd_data(rd_data), .rd_datavalid(rd_datavalid),
    .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mem_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - cur_base) >> 4;
    return tag == 0 ? {96'd0, idx} : {tag, a, 32'h0, idx};
  endfunction

  function automatic logic [1407:0] model_row(input int r);
    logic [1407:0] v;
    for (int i = 0; i < 11; i++) v[128*i +: 128] = mem_word(cur_base + 32'(16 * (11 * r + i)));
    return v;
  endfunction

  always @(negedge clk) begin : bus
    logic wreq, rdy;
    logic [1407:0] er;
    wreq = wait_pct != 0 && $urandom_range(99) < wait_pct;
    rdy = ready_mode == 0 || (ready_mode == 2 && $urandom_range(1) == 1);
    if (rst_n && prev_stall) begin
      chk("hold_read", 128'(rd_read), 128'(1));
      chk("hold_addr", 128'(rd_addr), 128'(prev_addr));
    end
    if (rst_n && rd_read) rd_seen = 1;
    rd_datavalid = 1'b0;
    rd_data = {$urandom, $urandom, $urandom, $urandom};
    if (pend.size() > 0 && (dv_gap == 0 || $urandom_range(1) == 1)) begin
      rd_datavalid = 1'b1;
      rd_data = pend.pop_front();
    end
    if (rst_n && rd_read && !wreq) begin
      chk("rd_addr", 128'(rd_addr), 128'(cur_base + 32'(16 * n_issued)));
      pend.push_back(mem_word(rd_addr));
      last_addr = rd_addr;
      n_issued++;
    end
    if (rst_n && row_valid && rdy) begin
      if (exp_rows.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL extra_row: got row %0d want none", n_rows);
      end else begin
        er = exp_rows.pop_front();
        for (int i = 0; i < 11; i++) chk("row_word", row_data[128*i +: 128], er[128*i +: 128]);
      end
      last_row = row_data;
      n_rows++;
      hs_cyc = cyc;
    end
    if (rst_n && rd_read && !wreq) chk("credit", 128'(n_issued - 11 * n_rows <= 22), 128'(1));
    prev_stall = rst_n && rd_read && wreq;
    prev_addr = rd_addr;
    rd_waitrequest = wreq;
    row_ready = rdy;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", 128'(busy), 0);
    chk("rst_done", 128'(done), 0);
    chk("rst_rd_read", 128'(rd_read), 0);
    chk("rst_rd_addr", 128'(rd_addr), 0);
    chk("rst_row_valid", 128'(row_valid), 0);
    chk("rst_row_data", 128'(row_data != '0), 0);
    chk("rst_stall", 128'(stall_cycles), 0);
  endtask

  task automatic start_op(input logic [31:0] b, input int cnt, input logic [31:0] tg);
    cur_base = b;
    tag = tg;
    n_issued = 0;
    n_rows = 0;
    exp_rows.delete();
    for (int r = 0; r < cnt; r++) exp_rows.push_back(model_row(r));
    base_addr = b;
    row_count = 11'(cnt);
    start = 1'b1;
    step();
    start = 1'b0;
    start_cyc = cyc;
    if (cnt != 0) begin
      chk("first_read", 128'(rd_read), 128'(1));
      chk("first_addr", 128'(rd_addr), 128'(b));
      chk("busy_run", 128'(busy), 128'(1));
    end
  endtask

  task automatic wait_done(input int cnt, input int exp_lat);
    int lim;
    bit seen;
    lim = cnt * 88 + 200;
    seen = 0;
    for (int i = 0; i < lim; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      step();
    end
    if (!seen) begin
      checks++;
      errs++;
      $display("FAIL done_timeout: got no done within %0d cycles want done", lim);
    end else begin
      chk("done_busy", 128'(busy), 0);
      chk("rows_rx", 128'(n_rows), 128'(cnt));
      chk("rows_left", 128'(exp_rows.size()), 0);
      chk("words_issued", 128'(n_issued), 128'(11 * cnt));
      chk("done_after_hs", 128'(cyc - hs_cyc), 128'(1));
      if (exp_lat >= 0) chk("op_latency", 128'(cyc - start_cyc), 128'(exp_lat));
      step();
      chk("done_pulse", 128'(done), 0);
    end
  endtask

  initial begin
    repeat (3) step();
    chk_reset_outputs();
    rst_n = 1'b1;
    step();
    // zero-row command completes immediately without any reads
    rd_seen = 0;
    start_op(32'h700, 0, 0);
    chk("zero_done", 128'(done), 128'(1));
    chk("zero_busy", 128'(busy), 0);
    step();
    chk("zero_done_pulse", 128'(done), 0);
    repeat (3) step();
    chk("zero_no_read", 128'(rd_seen), 0);
    // single row, literal expectations
    start_op(32'h1000, 1, 0);
    wait_done(1, 13);
    chk("lit_addr_last", 128'(last_addr), 128'(32'h10A0));
    chk("lit_word0", last_row[127:0], 128'd0);
    chk("lit_word10", last_row[1407:1280], 128'd10);
    // full-speed burst
    start_op(32'h0002_0000, 3, 32'h22);
    wait_done(3, 35);
    // back-pressure bounds the read-ahead; start in RUN is ignored
    ready_mode = 1;
    start_op(32'h2000, 3, 32'h3);
    repeat (10) step();
    base_addr = 32'hDEAD_0000;
    row_count = 11'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (70) step();
    chk("credit_issued", 128'(n_issued), 128'(22));
    chk("credit_rd_read", 128'(rd_read), 0);
    chk("credit_rows", 128'(n_rows), 0);
    chk("credit_valid", 128'(row_valid), 128'(1));
    ready_mode = 0;
    wait_done(3, -1);
    // random wait states, data gaps and consumer stalls
    ready_mode = 2;
    wait_pct = 50;
    dv_gap = 1;
    start_op(32'h0001_0000, 4, 32'h4);
    wait_done(4, -1);
    ready_mode = 0;
    wait_pct = 0;
    dv_gap = 0;
    // reset in the middle of a row with data still in flight
    start_op(32'h3000, 2, 32'h5);
    repeat (6) step();
    rst_n = 1'b0;
    exp_rows.delete();
    n_issued = 0;
    n_rows = 0;
    step();
    chk_reset_outputs();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 50 && pend.size() > 0; i++) step();
    repeat (2) step();
    chk("post_rst_pend", 128'(pend.size()), 0);
    chk("post_rst_valid", 128'(row_valid), 0);
    chk("post_rst_busy", 128'(busy), 0);
    chk("post_rst_read", 128'(rd_read), 0);
    start_op(32'h4000, 1, 32'h6);
    wait_done(1, 13);
    // stall counter over five held cycles
    ready_mode = 1;
    start_op(32'h5000, 1, 32'h7);
    for (int i = 0; i < 100 && !row_valid; i++) step();
    repeat (5) step();
`ifdef ROW_PACKER_STALL_CNT_EN
    chk("stall_cycles", 128'(stall_cycles), 128'(5));
`else
    chk("stall_cycles", 128'(stall_cycles), 128'(0));
`endif
    ready_mode = 0;
    wait_done(1, -1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
